// File: rtl/cube_move_engine_if.sv
// cube_move_engine_if
// Groups the move-engine request/response signals between the move-list
// source and the engine.
//   master: start, inverse, moves_in, cube_in  -> engine
//           ready, done, cube_out, moves_applied, err, state_dbg <- engine
//   slave : the engine side of the same signals.
//
// Handshake: a request is accepted on a rising clock edge where start=1 and
// ready=1. moves_in, cube_in and inverse are sampled on that edge only.
// start while ready=0 is dropped, never queued. done is a one-cycle pulse
// marking cube_out/moves_applied/err as final; ready is already 1 in that
// cycle, so a new start there is accepted.
interface cube_move_engine_if #(
  parameter int MAX_MOVES = 50
);
  localparam int CNT_W = $clog2(MAX_MOVES + 1);

  logic                   start;
  logic                   inverse;
  logic [4*MAX_MOVES-1:0] moves_in;
  logic [161:0]           cube_in;
  logic                   ready;
  logic                   done;
  logic [161:0]           cube_out;
  logic [CNT_W-1:0]       moves_applied;
  logic                   err;
  logic [0:0]             state_dbg;

  modport master (
    output start, inverse, moves_in, cube_in,
    input  ready, done, cube_out, moves_applied, err, state_dbg
  );

  modport slave (
    input  start, inverse, moves_in, cube_in,
    output ready, done, cube_out, moves_applied, err, state_dbg
  );
endinterface

// File: rtl/cube_move_engine.sv
// cube_move_engine
// Applies a packed list of face-turn codes to a 54-sticker cube state, one
// quarter turn per clock. Forward mode runs slot 0 upward and stops at a STOP
// code; inverse mode runs every slot from the last down to 0, skipping STOP
// codes and applying each turn in the opposite direction, which undoes a
// forward run of the same list.
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      cube_move_engine_if.slave (request, state in/out, status)
// Sticker s = 9*face + pos lives at bits [3s+2:3s]; faces U0 R1 F2 D3 L4 B5.
module cube_move_engine #(
  parameter int MAX_MOVES = 50
) (
  input  logic                clock,
  input  logic                reset_n,
  cube_move_engine_if.slave   bus
);
  localparam int CNT_W = $clog2(MAX_MOVES + 1);
  localparam int PTR_W = (MAX_MOVES > 1) ? $clog2(MAX_MOVES) : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_MOVING = 1'b1;

  logic [0:0]             state;
  logic [4*MAX_MOVES-1:0] moves_q;
  logic                   inv_q;
  logic [PTR_W-1:0]       ptr;
  logic [161:0]           cube_q;
  logic [CNT_W-1:0]       applied_q;
  logic                   err_q;
  logic                   done_q;

  logic [3:0]   slot_code;
  logic [3:0]   eff_code;
  logic         is_stop;
  logic         is_legal;
  logic         last_slot;
  logic         finish;
  logic [161:0] cube_next;

  // Moves one sticker orbit a->b->d->e->a (clockwise sense); ccw runs it backwards.
  function automatic logic [161:0] cyc4(input logic [161:0] c, input int a, input int b,
                                        input int d, input int e, input logic ccw);
    logic [161:0] n;
    n = c;
    if (!ccw) begin
      n[3*b +: 3] = c[3*a +: 3];
      n[3*d +: 3] = c[3*b +: 3];
      n[3*e +: 3] = c[3*d +: 3];
      n[3*a +: 3] = c[3*e +: 3];
    end else begin
      n[3*a +: 3] = c[3*b +: 3];
      n[3*b +: 3] = c[3*d +: 3];
      n[3*d +: 3] = c[3*e +: 3];
      n[3*e +: 3] = c[3*a +: 3];
    end
    return n;
  endfunction

  // One quarter turn: three side orbits plus the face's own corner and edge
  // orbits. Orbits are disjoint, so chaining them through n is order-free.
  // code[0] selects the anticlockwise variant; centres are never touched.
  function automatic logic [161:0] turn(input logic [161:0] c, input logic [3:0] code);
    logic [161:0] n;
    logic         ccw;
    logic         rot;
    int           fb;
    n   = c;
    ccw = code[0];
    rot = 1'b1;
    fb  = 0;
    case (code[3:1])
      3'd1: begin // R
        fb = 9;
        n = cyc4(n, 20, 2, 51, 29, ccw);
        n = cyc4(n, 23, 5, 48, 32, ccw);
        n = cyc4(n, 26, 8, 45, 35, ccw);
      end
      3'd2: begin // U
        fb = 0;
        n = cyc4(n, 18, 36, 45, 9, ccw);
        n = cyc4(n, 19, 37, 46, 10, ccw);
        n = cyc4(n, 20, 38, 47, 11, ccw);
      end
      3'd3: begin // F
        fb = 18;
        n = cyc4(n, 6, 9, 29, 44, ccw);
        n = cyc4(n, 7, 12, 28, 41, ccw);
        n = cyc4(n, 8, 15, 27, 38, ccw);
      end
      3'd4: begin // L
        fb = 36;
        n = cyc4(n, 0, 18, 27, 53, ccw);
        n = cyc4(n, 3, 21, 30, 50, ccw);
        n = cyc4(n, 6, 24, 33, 47, ccw);
      end
      3'd5: begin // B
        fb = 45;
        n = cyc4(n, 2, 36, 33, 17, ccw);
        n = cyc4(n, 1, 39, 34, 14, ccw);
        n = cyc4(n, 0, 42, 35, 11, ccw);
      end
      3'd6: begin // D
        fb = 27;
        n = cyc4(n, 24, 15, 51, 42, ccw);
        n = cyc4(n, 25, 16, 52, 43, ccw);
        n = cyc4(n, 26, 17, 53, 44, ccw);
      end
      default: rot = 1'b0;
    endcase
    if (rot) begin
      n = cyc4(n, fb + 0, fb + 2, fb + 8, fb + 6, ccw);
      n = cyc4(n, fb + 1, fb + 5, fb + 7, fb + 3, ccw);
    end
    return n;
  endfunction

  always_comb begin
    slot_code = moves_q[4*(MAX_MOVES-1-int'(ptr)) +: 4];
    is_stop   = (slot_code == 4'd0);
    is_legal  = (slot_code >= 4'd2) && (slot_code <= 4'd13);
    // Inverse replay flips direction: R<->Ri is just the low code bit.
    eff_code  = inv_q ? (slot_code ^ 4'd1) : slot_code;
    cube_next = turn(cube_q, eff_code);
    last_slot = inv_q ? (ptr == '0) : (ptr == PTR_W'(MAX_MOVES - 1));
    // STOP ends a forward run only; inverse always walks every slot.
    finish    = last_slot || (!inv_q && is_stop);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      moves_q   <= '0;
      inv_q     <= 1'b0;
      ptr       <= '0;
      cube_q    <= '0;
      applied_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            moves_q   <= bus.moves_in;
            inv_q     <= bus.inverse;
            cube_q    <= bus.cube_in;
            applied_q <= '0;
            err_q     <= 1'b0;
            ptr       <= bus.inverse ? PTR_W'(MAX_MOVES - 1) : '0;
            state     <= S_MOVING;
          end
        end
        S_MOVING: begin
          if (is_legal) begin
            cube_q    <= cube_next;
            applied_q <= applied_q + CNT_W'(1);
          end else if (!is_stop) begin
            err_q <= 1'b1;
          end
          if (finish) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end else begin
            ptr <= inv_q ? (ptr - PTR_W'(1)) : (ptr + PTR_W'(1));
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready         = (state == S_IDLE);
  assign bus.done          = done_q;
  assign bus.cube_out      = cube_q;
  assign bus.moves_applied = applied_q;
  assign bus.err           = err_q;
  assign bus.state_dbg     = state;
endmodule
